// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative signed multiply/divide unit:
// FSM encoding, default widths and the most negative operand value.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_CNT_W = 6;

  localparam logic [MD_WIDTH-1:0] MD_INT_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } md_state_e;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide loop; 'last' flags the final
// iteration so the FSM can leave the compute state on that edge.
module multdiv_counter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (radix-2 Booth) and restoring divider with a
// fixed WIDTH+1 cycle latency, answering the pipeline's multdiv handshake.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e state, state_next;

  logic accept, start_mult, start_div, cnt_en, last;

  // Operand latches shared by both datapaths
  logic [WIDTH-1:0] op_a, op_b;
  logic             is_mult;

  logic [2*WIDTH:0] prod;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;

  logic [WIDTH:0]   acc_ext, mcand_ext, booth_sum;
  logic [WIDTH-1:0] mag_b, quo_signed, fix_result;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge, mult_exc, div_zero, div_ovf, fix_exc;

  multdiv_counter #(
    .WIDTH (WIDTH),
    .CNT_W (MD_CNT_W)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (cnt_en),
    .last   (last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (ctrl_MULT)     state_next = MULT;
        else if (ctrl_DIV) state_next = DIV;
        else               state_next = IDLE;
      end
      MULT:    state_next = last ? FIX : MULT;
      DIV:     state_next = last ? FIX : DIV;
      FIX:     state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // A start in DONE is taken exactly like one in IDLE, giving no dead cycle
  always_comb begin
    accept         = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
    start_mult     = accept && ctrl_MULT;
    start_div      = accept && !ctrl_MULT;
    cnt_en         = (state == MULT) || (state == DIV);
    busy           = (state != IDLE);
    data_resultRDY = (state == DONE);
  end

  // Booth step: the sum is kept one bit wider so the shift brings in the
  // true sign even when acc +/- multiplicand overflows WIDTH bits.
  always_comb begin
    acc_ext   = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    mcand_ext = {op_a[WIDTH-1], op_a};
    case (prod[1:0])
      2'b01:   booth_sum = acc_ext + mcand_ext;
      2'b10:   booth_sum = acc_ext - mcand_ext;
      default: booth_sum = acc_ext;
    endcase
  end

  always_comb begin
    mag_b     = op_b[WIDTH-1] ? -op_b : op_b;
    div_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_b};
    div_ge    = rem[WIDTH] || (div_shift >= {1'b0, mag_b});
  end

  always_comb begin
    mult_exc   = !((&prod[2*WIDTH:WIDTH]) || !(|prod[2*WIDTH:WIDTH]));
    quo_signed = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) ? -quo : quo;
    div_zero   = (op_b == '0);
    div_ovf    = (op_a == INT_MIN) && (&op_b);
    fix_result = '0;
    fix_exc    = 1'b0;
    if (is_mult) begin
      fix_result = prod[WIDTH:1];
      fix_exc    = mult_exc;
    end else if (div_zero) begin
      fix_exc    = 1'b1;
    end else if (div_ovf) begin
      fix_result = INT_MIN;
      fix_exc    = 1'b1;
    end else begin
      fix_result = quo_signed;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_a           <= '0;
      op_b           <= '0;
      is_mult        <= 1'b0;
      prod           <= '0;
      rem            <= '0;
      quo            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start_mult) begin
      op_a    <= data_operandA;
      op_b    <= data_operandB;
      is_mult <= 1'b1;
      prod    <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
    end else if (start_div) begin
      op_a    <= data_operandA;
      op_b    <= data_operandB;
      is_mult <= 1'b0;
      rem     <= '0;
      quo     <= data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    end else if (state == MULT) begin
      prod <= {booth_sum, prod[WIDTH:1]};
    end else if (state == DIV) begin
      rem <= div_ge ? div_diff : div_shift;
      quo <= {quo[WIDTH-2:0], div_ge};
    end else if (state == FIX) begin
      data_result    <= fix_result;
      data_exception <= fix_exc;
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: expected results are queued when each
// operation starts and popped when the data_resultRDY pulse arrives.
module tb_multdiv_unit;
  import multdiv_pkg::*;

  localparam int W = MD_WIDTH;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int assert_count = 0;
  int fail_count = 0;

  logic [W:0] exp_q[$];

  multdiv_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  // Reference: {exception, result} from 64-bit arithmetic
  function automatic logic [W:0] model(input logic is_mult, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    longint p;
    logic [W-1:0] r;
    if (is_mult) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[W-1:0];
      return {(p != longint'($signed(r))), r};
    end
    if (b == '0) return {1'b1, {W{1'b0}}};
    if (a == MD_INT_MIN && b == '1) return {1'b1, MD_INT_MIN};
    r = W'($signed(a) / $signed(b));
    return {1'b0, r};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic m, input logic d, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    exp_q.push_back(model(m, a, b));
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  // Called one step after the start edge (or 'offset' edges later); leaves
  // the bench inside the DONE cycle.
  task automatic wait_result(input string tag, input int offset);
    int n;
    logic [W:0] e;
    n = offset;
    while (data_resultRDY !== 1'b1 && n < 40) begin
      check({tag, " busy"}, 64'(busy), 64'd1);
      @(posedge clock);
      #1;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " rdy"}, 64'(data_resultRDY), 64'd1);
    check({tag, " busy in done"}, 64'(busy), 64'd1);
    check({tag, " queue"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, " result"}, 64'(data_result), 64'(e[W-1:0]));
      check({tag, " exception"}, 64'(data_exception), 64'(e[W]));
    end
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clock);
    #1;
    check({tag, " rdy drop"}, 64'(data_resultRDY), 64'd0);
    check({tag, " busy drop"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic seen_rdy;
    logic [W-1:0] ra, rb;

    repeat (3) @(posedge clock);
    #1;
    check("reset result", 64'(data_result), 64'd0);
    check("reset exception", 64'(data_exception), 64'd0);
    check("reset rdy", 64'(data_resultRDY), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("idle busy", 64'(busy), 64'd0);

    start_op(1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC);
    wait_result("mul 3*-4", 0);
    check("mul 3*-4 const", 64'(data_result), 64'h0000_0000_FFFF_FFF4);
    expect_idle("mul 3*-4");

    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_result("mul ovf", 0);
    check("mul ovf exc const", 64'(data_exception), 64'd1);
    expect_idle("mul ovf");

    start_op(1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_8000);
    wait_result("mul intmin", 0);
    check("mul intmin const", 64'(data_result), 64'h0000_0000_8000_0000);
    expect_idle("mul intmin");

    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_result("div -7/2", 0);
    check("div -7/2 const", 64'(data_result), 64'h0000_0000_FFFF_FFFD);
    expect_idle("div -7/2");

    start_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_result("div 7/-2", 0);
    expect_idle("div 7/-2");

    start_op(1'b0, 1'b1, 32'd100, 32'd7);
    wait_result("div 100/7", 0);
    check("div 100/7 const", 64'(data_result), 64'd14);
    expect_idle("div 100/7");

    start_op(1'b0, 1'b1, 32'd5, 32'd0);
    wait_result("div by zero", 0);
    expect_idle("div by zero");

    start_op(1'b0, 1'b1, MD_INT_MIN, 32'hFFFF_FFFF);
    wait_result("div ovf", 0);
    expect_idle("div ovf");

    // Mid-operation DIV pulse and operand changes must be ignored
    start_op(1'b1, 1'b0, 32'd123, 32'hFFFF_FFD3);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    ctrl_DIV = 1'b1;
    data_operandA = 32'd77;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    wait_result("mul ignore div", 6);
    start_op(1'b1, 1'b0, 32'hFFFF_FC18, 32'd999);
    wait_result("back to back", 0);
    expect_idle("back to back");

    start_op(1'b1, 1'b1, 32'd9, 32'd11);
    wait_result("mult wins", 0);
    check("mult wins const", 64'(data_result), 64'd99);
    expect_idle("mult wins");

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : W'($urandom_range(1, 1000));
      start_op(i % 2 == 0, i % 2 != 0, ra, rb);
      wait_result("random op", 0);
      expect_idle("random op");
    end

    // Asynchronous reset during iteration 10 of a multiply
    start_op(1'b1, 1'b0, 32'd1000, 32'd1000);
    repeat (10) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("abort result", 64'(data_result), 64'd0);
    check("abort exception", 64'(data_exception), 64'd0);
    check("abort rdy", 64'(data_resultRDY), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    void'(exp_q.pop_front());
    @(posedge clock);
    #1;
    reset = 1'b0;
    seen_rdy = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      seen_rdy = seen_rdy | data_resultRDY;
    end
    check("no rdy after abort", 64'(seen_rdy), 64'd0);
    start_op(1'b1, 1'b0, 32'd6, 32'd7);
    wait_result("mul after reset", 0);
    check("mul after reset const", 64'(data_result), 64'd42);
    expect_idle("mul after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
